// File: rtl/axi_config_rd_pkg.sv
// AXI response and burst encodings shared by the config-register read and write slaves.
package axi_config_rd_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

endpackage

// File: rtl/axi_config_rd.sv
// AXI4 read slave: turns each AR burst into one config-register read per beat and
// returns the words as R beats, strictly one read outstanding at a time.
module axi_config_rd
  import axi_config_rd_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 8,
  parameter int RUSER_ENABLE = 0,
  parameter int RUSER_WIDTH  = 1,
  parameter int ARUSER_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    rd,
  output logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic [RUSER_WIDTH-1:0]  rd_user,
  input  logic                    rd_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    arready_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              count_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [RUSER_WIDTH-1:0]  ruser_q;
  logic                    rlast_q;
  logic                    rvalid_q;

  // Burst type, size, cache attributes etc. are accepted but have no effect.
  logic unused_ar;
  assign unused_ar = ^{s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                       s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser};

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s_axi_arvalid && arready_q) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (rd_valid) state_d = ST_RESP;
      ST_RESP:  if (s_axi_rready) state_d = (count_q == 8'd0) ? ST_IDLE : ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      ruser_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            id_q      <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            count_q   <= s_axi_arlen;
          end
        end
        ST_WAIT: begin
          if (rd_valid) begin
            rdata_q  <= rd_data;
            ruser_q  <= (RUSER_ENABLE != 0) ? rd_user : '0;
            rlast_q  <= (count_q == 8'd0);
            rvalid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          // R regs double as the one-entry output buffer; they hold until accepted.
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (count_q == 8'd0) begin
              arready_q <= 1'b1;
            end else begin
              count_q <= count_q - 8'd1;
              addr_q  <= addr_q + ADDR_WIDTH'(STRB_WIDTH);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_ruser   = ruser_q;
  assign s_axi_rvalid  = rvalid_q;
  assign rd            = (state_q == ST_ISSUE);
  assign raddr         = addr_q;

endmodule

// File: tb/tb_axi_config_rd.sv
// Directed bench for axi_config_rd: single/multi-beat bursts, stalls, address wrap,
// async reset mid-burst, and a 256-beat burst with AR held valid.
module tb_axi_config_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [0:0]  s_axi_ruser;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        rd;
  logic [31:0] raddr;
  logic [31:0] rd_data = '0;
  logic [0:0]  rd_user = '0;
  logic        rd_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_config_rd dut (
    .clk            (clk),
    .rst            (rst),
    .s_axi_arid     (s_axi_arid),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arlen    (s_axi_arlen),
    .s_axi_arsize   (3'd2),
    .s_axi_arburst  (2'b01),
    .s_axi_arlock   (1'b0),
    .s_axi_arcache  (4'd0),
    .s_axi_arprot   (3'd0),
    .s_axi_arqos    (4'd0),
    .s_axi_arregion (4'd0),
    .s_axi_aruser   (1'b0),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_rid      (s_axi_rid),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rlast    (s_axi_rlast),
    .s_axi_ruser    (s_axi_ruser),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .rd             (rd),
    .raddr          (raddr),
    .rd_data        (rd_data),
    .rd_user        (rd_user),
    .rd_valid       (rd_valid)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise ARVALID only once ARREADY is seen, so the handshake lands on the next edge.
  task automatic ar_start(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] id, input string tag);
    int n = 0;
    while (!s_axi_arready && n < 20) begin
      tick();
      n++;
    end
    check({tag, " arready"}, s_axi_arready, 1);
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arid    = id;
    s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    check({tag, " arready low after AR"}, s_axi_arready, 0);
    check({tag, " rd at T+1"}, rd, 1);
  endtask

  // One beat: see rd, answer after rv_delay cycles, stall RREADY, then accept.
  task automatic do_beat(input logic [31:0] exp_addr, input logic [31:0] data,
                         input int rv_delay, input int stall, input bit stray,
                         input bit exp_last, input logic [7:0] exp_id, input string tag);
    int n = 0;
    while (!rd && n < 20) begin
      tick();
      n++;
    end
    check({tag, " rd"}, rd, 1);
    check({tag, " raddr"}, raddr, exp_addr);
    tick();
    check({tag, " rd single cycle"}, rd, 0);
    for (int i = 1; i < rv_delay; i++) tick();
    check({tag, " rvalid before data"}, s_axi_rvalid, 0);
    rd_valid = 1'b1;
    rd_data  = data;
    tick();
    rd_valid = 1'b0;
    rd_data  = 32'h0BAD_0BAD;
    check({tag, " rvalid"}, s_axi_rvalid, 1);
    check({tag, " rdata"}, s_axi_rdata, data);
    check({tag, " rid"}, s_axi_rid, exp_id);
    check({tag, " rresp"}, s_axi_rresp, 0);
    check({tag, " rlast"}, s_axi_rlast, exp_last);
    for (int i = 0; i < stall; i++) begin
      if (stray) rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
      check({tag, " stall rvalid"}, s_axi_rvalid, 1);
      check({tag, " stall rdata"}, s_axi_rdata, data);
      check({tag, " stall no rd"}, rd, 0);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check({tag, " rvalid drop"}, s_axi_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("reset arready", s_axi_arready, 0);
    check("reset rvalid", s_axi_rvalid, 0);
    check("reset rd", rd, 0);
    check("reset rlast", s_axi_rlast, 0);
    check("reset rdata", s_axi_rdata, 0);
    tick();
    tick();
    rst = 1'b0;
    check("arready low until edge", s_axi_arready, 0);
    tick();
    check("arready after reset", s_axi_arready, 1);

    // 1: single beat
    ar_start(32'h100, 8'd0, 8'h5a, "t1");
    do_beat(32'h100, 32'hDEADBEEF, 1, 0, 1'b0, 1'b1, 8'h5a, "t1 b0");
    check("t1 arready back", s_axi_arready, 1);
    check("t1 no rd after", rd, 0);

    // 2: four beats, incrementing
    ar_start(32'h200, 8'd3, 8'h21, "t2");
    do_beat(32'h200, 32'h1111_1111, 1, 0, 1'b0, 1'b0, 8'h21, "t2 b0");
    do_beat(32'h204, 32'h2222_2222, 1, 0, 1'b0, 1'b0, 8'h21, "t2 b1");
    do_beat(32'h208, 32'h3333_3333, 1, 0, 1'b0, 1'b0, 8'h21, "t2 b2");
    do_beat(32'h20C, 32'h4444_4444, 1, 0, 1'b0, 1'b1, 8'h21, "t2 b3");
    check("t2 arready back", s_axi_arready, 1);

    // 3: slow register file, RREADY stalls, stray rd_valid during RESP
    ar_start(32'h400, 8'd1, 8'h33, "t3");
    do_beat(32'h400, 32'hCAFE_0001, 5, 3, 1'b1, 1'b0, 8'h33, "t3 b0");
    do_beat(32'h404, 32'hCAFE_0002, 5, 3, 1'b1, 1'b1, 8'h33, "t3 b1");
    rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_valid = 1'b0;
    check("t3 no extra beat", s_axi_rvalid, 0);
    check("t3 no extra rd", rd, 0);
    check("t3 arready idle", s_axi_arready, 1);

    // 4: address wraps past 2^32
    ar_start(32'hFFFF_FFF8, 8'd3, 8'h44, "t4");
    do_beat(32'hFFFF_FFF8, 32'h0000_0A01, 1, 0, 1'b0, 1'b0, 8'h44, "t4 b0");
    do_beat(32'hFFFF_FFFC, 32'h0000_0A02, 1, 0, 1'b0, 1'b0, 8'h44, "t4 b1");
    do_beat(32'h0000_0000, 32'h0000_0A03, 1, 0, 1'b0, 1'b0, 8'h44, "t4 b2");
    do_beat(32'h0000_0004, 32'h0000_0A04, 1, 0, 1'b0, 1'b1, 8'h44, "t4 b3");

    // 5: async reset while beat 2 of 4 is waiting for RREADY
    ar_start(32'h300, 8'd3, 8'h55, "t5");
    do_beat(32'h300, 32'h5555_0000, 1, 0, 1'b0, 1'b0, 8'h55, "t5 b0");
    check("t5 b1 rd", rd, 1);
    tick();
    rd_valid = 1'b1;
    rd_data  = 32'h5555_0001;
    tick();
    rd_valid = 1'b0;
    check("t5 b1 rvalid", s_axi_rvalid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("t5 rvalid drops async", s_axi_rvalid, 0);
    check("t5 rlast drops async", s_axi_rlast, 0);
    check("t5 rd drops async", rd, 0);
    check("t5 arready drops async", s_axi_arready, 0);
    s_axi_rready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    s_axi_rready = 1'b0;
    check("t5 no beat after reset", s_axi_rvalid, 0);
    check("t5 arready after reset", s_axi_arready, 1);
    ar_start(32'h600, 8'd0, 8'h56, "t5 new");
    do_beat(32'h600, 32'h6060_6060, 1, 0, 1'b0, 1'b1, 8'h56, "t5 new b0");

    // 6: 256-beat burst with ARVALID held, second burst queued behind it
    while (!s_axi_arready) tick();
    s_axi_araddr  = 32'h1000;
    s_axi_arlen   = 8'd255;
    s_axi_arid    = 8'h66;
    s_axi_arvalid = 1'b1;
    tick();
    check("t6 rd at T+1", rd, 1);
    s_axi_araddr = 32'h2000;
    s_axi_arlen  = 8'd0;
    s_axi_arid   = 8'h77;
    for (int i = 0; i < 256; i++) begin
      check($sformatf("t6 arready low b%0d", i), s_axi_arready, 0);
      do_beat(32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i), 1, 0, 1'b0,
              (i == 255), 8'h66, $sformatf("t6 b%0d", i));
    end
    check("t6 arready after last", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    check("t6 second burst rd", rd, 1);
    check("t6 second burst arready", s_axi_arready, 0);
    do_beat(32'h2000, 32'h1234_5678, 1, 0, 1'b0, 1'b1, 8'h77, "t6 second");
    check("t6 idle at end", s_axi_arready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
